// File: rtl/prime_cnt_pkg.sv
// Shared types and constants for the prime-sequence counter.
package prime_cnt_pkg;

  typedef enum logic [1:0] {IDLE, ADVANCE, TEST} state_t;

  localparam int RESET_COUNT = 2;

  // Divisor width: trial divisors never exceed ceil(WIDTH/2)+1 bits.
  function automatic int div_width(input int width);
    return (width + 1) / 2 + 1;
  endfunction

endpackage

// File: rtl/prime_cand_test.sv
// Trial-division loop: one divisor per cycle until the candidate is decided.
module prime_cand_test
  import prime_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DW    = div_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cand,
  output logic             busy,
  output logic             is_prime,
  output logic             is_composite
);

  localparam int PW = 2 * DW;

  logic [DW-1:0]    d;
  logic [PW-1:0]    sq;
  logic [PW-1:0]    cand_ext;
  logic [WIDTH-1:0] rem;
  logic             below_two;

  always_comb begin
    sq        = PW'(d) * PW'(d);
    cand_ext  = PW'(cand);
    rem       = cand % WIDTH'(d);
    below_two = cand < WIDTH'(2);
  end

  // Order matters: cand<2 first, then the d*d>cand exit, then divisibility.
  always_comb begin
    is_prime     = busy && !below_two && (sq > cand_ext);
    is_composite = busy && (below_two || ((sq <= cand_ext) && (rem == '0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      d    <= DW'(2);
    end else if (start) begin
      busy <= 1'b1;
      d    <= DW'(2);
    end else if (busy) begin
      if (is_prime || is_composite) busy <= 1'b0;
      else                          d    <= d + DW'(1);
    end
  end

endmodule

// File: rtl/prime_seq_counter.sv
// Prime-sequence counter with step/ready handshake; down counting enabled by PRIME_CNT_DOWN_EN.
module prime_seq_counter
  import prime_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             ready,
  output logic             done,
  output logic             wrap
);

  localparam int             DW      = div_width(WIDTH);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_COUNT);

  state_t           state, state_nx;
  logic [WIDTH-1:0] cand;
  logic             wrap_flag;
  logic             start;
  logic             is_prime, is_composite;
  logic             busy_unused;

`ifdef PRIME_CNT_DOWN_EN
  logic dir_q;
`else
  logic unused_dir;
  assign unused_dir = dir;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (step) state_nx = ADVANCE;
      ADVANCE: state_nx = TEST;
      TEST: begin
        if (is_prime)          state_nx = IDLE;
        else if (is_composite) state_nx = ADVANCE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    start = (state == ADVANCE);
  end

  // cand is seeded from count on accept, so ADVANCE always steps from cand.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= RST_VAL;
      cand      <= RST_VAL;
      wrap_flag <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
`ifdef PRIME_CNT_DOWN_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: if (step) begin
          cand      <= count;
          wrap_flag <= 1'b0;
`ifdef PRIME_CNT_DOWN_EN
          dir_q     <= dir;
`endif
        end
        ADVANCE: begin
`ifdef PRIME_CNT_DOWN_EN
          if (dir_q) begin
            if (cand == RST_VAL) begin
              cand      <= MAX_VAL;
              wrap_flag <= 1'b1;
            end else begin
              cand <= cand - WIDTH'(1);
            end
          end else
`endif
          if (cand == MAX_VAL) begin
            cand      <= RST_VAL;
            wrap_flag <= 1'b1;
          end else begin
            cand <= cand + WIDTH'(1);
          end
        end
        TEST: if (is_prime) begin
          count     <= cand;
          done      <= 1'b1;
          wrap      <= wrap_flag;
          wrap_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  prime_cand_test #(.WIDTH(WIDTH), .DW(DW)) u_test (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cand         (cand),
    .busy         (busy_unused),
    .is_prime     (is_prime),
    .is_composite (is_composite)
  );

endmodule

// File: tb/tb_prime_seq_counter.sv
// Self-checking bench for prime_seq_counter (WIDTH=4 and WIDTH=8 instances).
module tb_prime_seq_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0, dir = 1'b0;
  logic [3:0] count;
  logic       ready, done, wrap;
  logic       step8 = 1'b0, dir8 = 1'b0;
  logic [7:0] count8;
  logic       ready8, done8, wrap8;

  int vectors = 0;
  int miscompares = 0;
  int model4 = 2;
  int model8 = 2;

  always #5 clk = ~clk;

  prime_seq_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .step(step), .dir(dir),
    .count(count), .ready(ready), .done(done), .wrap(wrap));

  prime_seq_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .step(step8), .dir(dir8),
    .count(count8), .ready(ready8), .done(done8), .wrap(wrap8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_prime_m(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++) if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Cycles spent testing one candidate: divisors 2,3,... up to and including the deciding one.
  function automatic int tries_m(input int c);
    int t = 0;
    if (c < 2) return 1;
    for (int k = 2; ; k++) begin
      t++;
      if (k * k > c || c % k == 0) break;
    end
    return t;
  endfunction

  task automatic next_m(input int cur, input bit down, input int w,
                        output int nxt, output bit wr, output int lat);
    int maxv = (1 << w) - 1;
    int c = cur;
    wr = 1'b0;
    lat = 0;
    do begin
      if (down) begin
        if (c == 2) begin c = maxv; wr = 1'b1; end else c--;
      end else begin
        if (c == maxv) begin c = 2; wr = 1'b1; end else c++;
      end
      lat += 1 + tries_m(c);
    end while (!is_prime_m(c));
    nxt = c;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model4 = 2;
    model8 = 2;
  endtask

  task automatic do_step(input bit d, input bit extra, output int lat);
    int exp_n, exp_l;
    bit exp_w, down;
`ifdef PRIME_CNT_DOWN_EN
    down = d;
`else
    down = 1'b0;
`endif
    next_m(model4, down, 4, exp_n, exp_w, exp_l);
    @(negedge clk); step = 1'b1; dir = d;
    @(posedge clk); #1;
    step = extra;
    chk("ready_low", ready, 0);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      step = 1'b0;
      lat++;
      if (done) break;
      chk("busy_no_ready", ready, 0);
    end
    chk("done", done, 1);
    chk("latency", lat, exp_l);
    chk("count", count, exp_n);
    chk("wrap", wrap, exp_w);
    chk("ready_done", ready, 1);
    model4 = exp_n;
  endtask

  task automatic do_step8();
    int exp_n, exp_l, lat;
    bit exp_w;
    next_m(model8, 1'b0, 8, exp_n, exp_w, exp_l);
    @(negedge clk); step8 = 1'b1;
    @(posedge clk); #1;
    step8 = 1'b0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (done8) break;
    end
    chk("w8_done", done8, 1);
    chk("w8_latency", lat, exp_l);
    chk("w8_count", count8, exp_n);
    chk("w8_wrap", wrap8, exp_w);
    model8 = exp_n;
  endtask

  initial begin
    int lat, pulses;
    int seq_up [6] = '{3, 5, 7, 11, 13, 2};

    // reset state, with a step presented during reset that must be dropped
    @(negedge clk); rst = 1'b1; step = 1'b1;
    @(negedge clk); rst = 1'b0; step = 1'b0;
    #1;
    chk("rst_count", count, 2);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    @(posedge clk); #1;
    chk("rst_step_dropped", ready, 1);

    // up sweep with wrap on 13->2
    for (int i = 0; i < 6; i++) begin
      do_step(1'b0, 1'b0, lat);
      chk("sweep_value", count, seq_up[i]);
      chk("sweep_wrap", wrap, (i == 5) ? 1 : 0);
      if (i == 0) chk("lat_2to3", lat, 2);
      if (i == 1) chk("lat_3to5", lat, 5);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("wrap_one_cycle", wrap, 0);

    // step while busy is ignored
    do_reset();
    do_step(1'b0, 1'b0, lat);
    do_step(1'b0, 1'b1, lat);
    chk("busy_count", count, 5);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("busy_extra_done", pulses, 0);
    chk("busy_hold", count, 5);

    // reset in the middle of the 7->11 search
    do_reset();
    repeat (3) do_step(1'b0, 1'b0, lat);
    chk("pre_mid_rst", count, 7);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_count", count, 2);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    model4 = 2;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    chk("mid_rst_hold", count, 2);

`ifdef PRIME_CNT_DOWN_EN
    do_reset();
    do_step(1'b1, 1'b0, lat);
    chk("down_wrap_cnt", count, 13);
    chk("down_wrap_flag", wrap, 1);
    do_step(1'b1, 1'b0, lat);
    chk("down_cnt", count, 11);
    chk("down_flag", wrap, 0);
`endif

    // randomized walk with random idle gaps (gap 0 exercises back-to-back steps)
    do_reset();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_step(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), lat);
    end

    // WIDTH=8: climb to 241, then 251 and wrap to 2
    do_reset();
    while (model8 != 241 && vectors < 20000) do_step8();
    chk("w8_at_241", count8, 241);
    do_step8();
    chk("w8_251", count8, 251);
    do_step8();
    chk("w8_wrap_to_2", count8, 2);
    chk("w8_wrap_flag", wrap8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prime_seq_counter.md
# prime_seq_counter

Parametrised prime-sequence counter: steps through the primes in [2, 2^WIDTH-1], up or down, on a step/ready handshake. The next prime is found at run time by a multi-cycle trial-division search, so one structure covers any WIDTH without per-width next-state logic. It replaces the fixed 4-bit flip-flop prime counters in the lab designs and drives display/sequence logic that consumes `count` on `done`.

## Interface
- WIDTH, 4, counter width in bits; legal range 3..16.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- step  in  1  request advance to next prime; accepted only when `ready`=1.
- dir  in  1  0 = up (next larger prime), 1 = down (next smaller prime); sampled with accepted `step`.
- count  out  WIDTH  current prime.
- ready  out  1  high in IDLE; new `step` can be accepted.
- done  out  1  one-cycle pulse, same cycle `count` first shows the new prime.
- wrap  out  1  one-cycle pulse with `done` when the advance crossed the range boundary.

## Operation
- Reset values: count=2, ready=1, done=0, wrap=0, state IDLE. Reset aborts any search in progress.
- States: IDLE, ADVANCE, TEST.
- IDLE: ready=1. step=1 → latch dir, go ADVANCE. step while not IDLE is ignored (not queued).
- ADVANCE: cand = cur+1 (up) / cur-1 (down); cur = count on first pass, else previous cand. Up with cur=2^WIDTH-1 → cand=2, set wrap flag. Down with cur=2 → cand=2^WIDTH-1, set wrap flag. Load d=2, go TEST.
- TEST, one divisor per cycle: cand<2 → composite; d*d > cand → prime: count<=cand, done=1, wrap=wrap flag, clear flag, go IDLE; cand mod d = 0 → composite, go ADVANCE; else d<=d+1, stay TEST.
- Arithmetic: cand is WIDTH bits; d is ceil(WIDTH/2)+1 bits; d*d compared at full product width, no truncation.
- Wrap targets: up from largest prime lands on 2; down from 2 lands on largest prime ≤ 2^WIDTH-1.
- rst and step in the same cycle: reset wins, step dropped.

## Timing
- step sampled at edge N → ADVANCE after N. Each candidate costs 1 ADVANCE cycle + 1 TEST cycle per divisor tried (including the deciding one).
- 2→3: count=3, done=1 after edge N+2. 3→5: after edge N+5.
- ready=0 from edge N until the edge that sets done; ready=1 in the done cycle, so a step in that cycle is accepted (back-to-back stepping).
- Worst-case latency bounded by prime gap × (1+sqrt(2^WIDTH)); no timeout.

## Configuration
- PRIME_CNT_DOWN_EN defined: `dir` behaves as above.
- Not defined: `dir` port present but ignored; always counts up; down-wrap logic absent.

## Structure
- Package prime_cnt_pkg: state enum (IDLE/ADVANCE/TEST), divisor-width constant function of WIDTH, reset value constant (2).
- One sub-module: prime_cand_test, the divisor loop (start, cand in; busy, is_prime, is_composite out); top holds count, dir, wrap flag and handshake.

## Test plan
- Reset, WIDTH=4: rst 1 cycle → count=2, ready=1, done=0, wrap=0.
- Up sweep WIDTH=4: 6 steps waiting for done → 3,5,7,11,13,2; wrap=1 only on 13→2; 3→5 latency exactly 5 edges.
- Down (PRIME_CNT_DOWN_EN), WIDTH=4 from 2: step dir=1 → 13 with wrap=1; next → 11, wrap=0.
- Step while busy: second step 1 cycle after first on 3→5 → ignored; single done, count=5.
- Reset mid-search: rst during TEST of 7→11 → next cycle count=2, ready=1, no done.
- WIDTH=8 up from 241: → 251; next step → 2 with wrap=1.
